// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM, one-cycle result strobes.
// Define UART_RX_PARITY_EN for 8E1 framing with an even-parity check before the stop bit.
module uart_rx #(
    parameter int clk_bit = 87
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       serial_in,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       active,
    output logic       frame_err,
    output logic       parity_err
);

    localparam logic [7:0] half = 8'((clk_bit - 1) / 2);
    localparam logic [7:0] last = 8'(clk_bit - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    state_t     state, state_n;
    logic [7:0] clk_count, clk_count_n;
    logic [2:0] bit_count, bit_count_n;
    logic [7:0] shift, shift_n;
    logic [7:0] data_n;
    logic       data_valid_n;
    logic       frame_err_n;
    logic       active_n;
    logic       sync_p0, sync_p1;
    logic       rx_s;
    logic       perr;

    assign rx_s = sync_p1;

`ifdef UART_RX_PARITY_EN
    logic par_bit, par_bit_n;
    logic parity_err_n;

    // Even parity: data bits XOR parity bit must be zero.
    assign perr = (^shift) ^ par_bit;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            par_bit    <= par_bit_n;
            parity_err <= parity_err_n;
        end
    end
`else
    assign perr       = 1'b0;
    assign parity_err = 1'b0;
`endif

    // Stage p0/p1: metastability synchronizer, idles high like the line.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= serial_in;
            sync_p1 <= sync_p0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            clk_count  <= 8'd0;
            bit_count  <= 3'd0;
            shift      <= 8'd0;
            data       <= 8'h00;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            active     <= 1'b0;
        end else begin
            state      <= state_n;
            clk_count  <= clk_count_n;
            bit_count  <= bit_count_n;
            shift      <= shift_n;
            data       <= data_n;
            data_valid <= data_valid_n;
            frame_err  <= frame_err_n;
            active     <= active_n;
        end
    end

    always_comb begin
        state_n      = state;
        clk_count_n  = clk_count;
        bit_count_n  = bit_count;
        shift_n      = shift;
        data_n       = data;
        data_valid_n = 1'b0;
        frame_err_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_n    = par_bit;
        parity_err_n = 1'b0;
`endif
        case (state)
            IDLE: begin
                clk_count_n = 8'd0;
                bit_count_n = 3'd0;
                if (!rx_s) state_n = START;
            end
            START: begin
                // Re-check the start bit at its centre to reject line glitches.
                if (clk_count == half) begin
                    clk_count_n = 8'd0;
                    state_n     = rx_s ? IDLE : DATA;
                end else begin
                    clk_count_n = clk_count + 8'd1;
                end
            end
            DATA: begin
                if (clk_count == last) begin
                    clk_count_n        = 8'd0;
                    shift_n[bit_count] = rx_s;
                    if (bit_count == 3'd7) begin
                        bit_count_n = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_n     = PARITY;
`else
                        state_n     = STOP;
`endif
                    end else begin
                        bit_count_n = bit_count + 3'd1;
                    end
                end else begin
                    clk_count_n = clk_count + 8'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (clk_count == last) begin
                    clk_count_n = 8'd0;
                    par_bit_n   = rx_s;
                    state_n     = STOP;
                end else begin
                    clk_count_n = clk_count + 8'd1;
                end
            end
`endif
            STOP: begin
                if (clk_count == last) begin
                    clk_count_n = 8'd0;
                    frame_err_n = !rx_s;
`ifdef UART_RX_PARITY_EN
                    parity_err_n = perr;
`endif
                    if (rx_s && !perr) begin
                        data_n       = shift;
                        data_valid_n = 1'b1;
                    end
                    state_n = CLEANUP;
                end else begin
                    clk_count_n = clk_count + 8'd1;
                end
            end
            CLEANUP: begin
                // Wait out a break so a held-low line cannot start a new frame.
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n     = IDLE;
                clk_count_n = 8'd0;
                bit_count_n = 3'd0;
            end
        endcase
        active_n = (state_n != IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at clk_bit=16; define UART_RX_PARITY_EN to exercise 8E1 framing.
module tb_uart_rx;

    localparam int CLK_BIT = 16;

    logic       i_clk;
    logic       i_rst_n;
    logic       serial_in;
    logic [7:0] data;
    logic       data_valid;
    logic       active;
    logic       frame_err;
    logic       parity_err;

    int n_vec;
    int n_err;

    int n_dv, n_fe, n_pe, n_overlap, n_wide;
    logic [7:0] dv_q[$];
    logic dv_prev, fe_prev, pe_prev;

    uart_rx #(.clk_bit(CLK_BIT)) dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .serial_in (serial_in),
        .data      (data),
        .data_valid(data_valid),
        .active    (active),
        .frame_err (frame_err),
        .parity_err(parity_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        n_dv = 0; n_fe = 0; n_pe = 0; n_overlap = 0; n_wide = 0;
        dv_prev = 1'b0; fe_prev = 1'b0; pe_prev = 1'b0;
    end

    // Strobe monitor, sampled on the inactive edge.
    always @(negedge i_clk) begin
        if (data_valid === 1'b1) begin
            n_dv = n_dv + 1;
            dv_q.push_back(data);
        end
        if (frame_err === 1'b1) n_fe = n_fe + 1;
        if (parity_err === 1'b1) n_pe = n_pe + 1;
        if (data_valid === 1'b1 && (frame_err === 1'b1 || parity_err === 1'b1))
            n_overlap = n_overlap + 1;
        if ((data_valid === 1'b1 && dv_prev) || (frame_err === 1'b1 && fe_prev) ||
            (parity_err === 1'b1 && pe_prev))
            n_wide = n_wide + 1;
        dv_prev = (data_valid === 1'b1);
        fe_prev = (frame_err === 1'b1);
        pe_prev = (parity_err === 1'b1);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t required < 400000", $time);
        $fatal(1, "watchdog");
    end

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (CLK_BIT) @(negedge i_clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^b);
`endif
        send_bit(stop);
    endtask

    task automatic idle_cycles(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic test_reset;
        i_rst_n   = 1'b0;
        serial_in = 1'b1;
        repeat (5) @(negedge i_clk);
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", data); end
        n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_dv: got %b want 0", data_valid); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL reset_active: got %b want 0", active); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_fe: got %b want 0", frame_err); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_pe: got %b want 0", parity_err); end
        i_rst_n = 1'b1;
        idle_cycles(20);
        n_vec++; if (n_dv !== 0) begin n_err++; $display("FAIL idle_no_dv: got %0d want 0", n_dv); end
        n_vec++; if (n_fe !== 0) begin n_err++; $display("FAIL idle_no_fe: got %0d want 0", n_fe); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL idle_active: got %b want 0", active); end
    endtask

    task automatic test_good_byte;
        int dv0, fe0;
        dv0 = n_dv; fe0 = n_fe;
        send_bit(1'b0);
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL good_active_start: got %b want 1", active); end
        for (int i = 0; i < 8; i++) send_bit(8'hA5 >> i);
`ifdef UART_RX_PARITY_EN
        send_bit(1'b0);
`endif
        send_bit(1'b1);
        idle_cycles(4);
        n_vec++; if (n_dv - dv0 !== 1) begin n_err++; $display("FAIL good_dv_count: got %0d want 1", n_dv - dv0); end
        n_vec++; if (dv_q[dv_q.size()-1] !== 8'hA5) begin n_err++; $display("FAIL good_dv_data: got %h want a5", dv_q[dv_q.size()-1]); end
        n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL good_data_hold: got %h want a5", data); end
        n_vec++; if (n_fe - fe0 !== 0) begin n_err++; $display("FAIL good_fe: got %0d want 0", n_fe - fe0); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL good_active_end: got %b want 0", active); end
    endtask

    task automatic test_glitch;
        int dv0, fe0;
        dv0 = n_dv; fe0 = n_fe;
        serial_in = 1'b0;
        repeat (3) @(negedge i_clk);
        serial_in = 1'b1;
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL glitch_active_seen: got %b want 1", active); end
        idle_cycles(40);
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL glitch_active_drop: got %b want 0", active); end
        n_vec++; if (n_dv - dv0 !== 0) begin n_err++; $display("FAIL glitch_dv: got %0d want 0", n_dv - dv0); end
        n_vec++; if (n_fe - fe0 !== 0) begin n_err++; $display("FAIL glitch_fe: got %0d want 0", n_fe - fe0); end
        n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL glitch_data: got %h want a5", data); end
    endtask

    task automatic test_frame_error;
        int dv0, fe0;
        dv0 = n_dv; fe0 = n_fe;
        send_frame(8'h3C, 1'b0);
        idle_cycles(2 * CLK_BIT);
        n_vec++; if (n_fe - fe0 !== 1) begin n_err++; $display("FAIL ferr_count: got %0d want 1", n_fe - fe0); end
        n_vec++; if (n_dv - dv0 !== 0) begin n_err++; $display("FAIL ferr_dv: got %0d want 0", n_dv - dv0); end
        n_vec++; if (data !== 8'hA5) begin n_err++; $display("FAIL ferr_data: got %h want a5", data); end
        fe0 = n_fe;
        serial_in = 1'b0;
        repeat (40 * CLK_BIT) @(negedge i_clk);
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL break_active_held: got %b want 1", active); end
        idle_cycles(3 * CLK_BIT);
        n_vec++; if (n_fe - fe0 !== 1) begin n_err++; $display("FAIL break_fe_count: got %0d want 1", n_fe - fe0); end
        n_vec++; if (n_dv - dv0 !== 0) begin n_err++; $display("FAIL break_dv: got %0d want 0", n_dv - dv0); end
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL break_active_end: got %b want 0", active); end
    endtask

    task automatic test_back_to_back;
        int dv0;
        dv0 = n_dv;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        idle_cycles(2 * CLK_BIT);
        n_vec++; if (n_dv - dv0 !== 3) begin n_err++; $display("FAIL b2b_count: got %0d want 3", n_dv - dv0); end
        if (dv_q.size() >= dv0 + 3) begin
            n_vec++; if (dv_q[dv0] !== 8'h00) begin n_err++; $display("FAIL b2b_byte0: got %h want 00", dv_q[dv0]); end
            n_vec++; if (dv_q[dv0+1] !== 8'hFF) begin n_err++; $display("FAIL b2b_byte1: got %h want ff", dv_q[dv0+1]); end
            n_vec++; if (dv_q[dv0+2] !== 8'h55) begin n_err++; $display("FAIL b2b_byte2: got %h want 55", dv_q[dv0+2]); end
        end
        n_vec++; if (data !== 8'h55) begin n_err++; $display("FAIL b2b_data: got %h want 55", data); end
    endtask

    task automatic test_reset_mid_frame;
        int dv0, fe0, pe0;
        send_frame(8'h00, 1'b1);
        dv0 = n_dv; fe0 = n_fe; pe0 = n_pe;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        n_vec++; if (active !== 1'b1) begin n_err++; $display("FAIL mid_active_before: got %b want 1", active); end
        i_rst_n = 1'b0;
        repeat (5) @(negedge i_clk);
        n_vec++; if (active !== 1'b0) begin n_err++; $display("FAIL mid_active_in_reset: got %b want 0", active); end
        i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        idle_cycles(2 * CLK_BIT);
        n_vec++; if (n_dv - dv0 !== 0) begin n_err++; $display("FAIL mid_dv: got %0d want 0", n_dv - dv0); end
        n_vec++; if (n_fe - fe0 !== 0) begin n_err++; $display("FAIL mid_fe: got %0d want 0", n_fe - fe0); end
        n_vec++; if (n_pe - pe0 !== 0) begin n_err++; $display("FAIL mid_pe: got %0d want 0", n_pe - pe0); end
        n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL mid_data_reset: got %h want 00", data); end
        send_frame(8'h3C, 1'b1);
        idle_cycles(2 * CLK_BIT);
        n_vec++; if (n_dv - dv0 !== 1) begin n_err++; $display("FAIL mid_next_dv: got %0d want 1", n_dv - dv0); end
        n_vec++; if (data !== 8'h3C) begin n_err++; $display("FAIL mid_next_data: got %h want 3c", data); end
    endtask

    task automatic test_parity;
`ifdef UART_RX_PARITY_EN
        int dv0, pe0;
        dv0 = n_dv; pe0 = n_pe;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'h07 >> i);
        send_bit(1'b1);
        send_bit(1'b1);
        idle_cycles(2 * CLK_BIT);
        n_vec++; if (n_dv - dv0 !== 1) begin n_err++; $display("FAIL par_good_dv: got %0d want 1", n_dv - dv0); end
        n_vec++; if (data !== 8'h07) begin n_err++; $display("FAIL par_good_data: got %h want 07", data); end
        n_vec++; if (n_pe - pe0 !== 0) begin n_err++; $display("FAIL par_good_pe: got %0d want 0", n_pe - pe0); end
        dv0 = n_dv;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(8'h07 >> i);
        send_bit(1'b0);
        send_bit(1'b1);
        idle_cycles(2 * CLK_BIT);
        n_vec++; if (n_pe - pe0 !== 1) begin n_err++; $display("FAIL par_bad_pe: got %0d want 1", n_pe - pe0); end
        n_vec++; if (n_dv - dv0 !== 0) begin n_err++; $display("FAIL par_bad_dv: got %0d want 0", n_dv - dv0); end
        n_vec++; if (data !== 8'h07) begin n_err++; $display("FAIL par_bad_data: got %h want 07", data); end
`else
        n_vec++; if (n_pe !== 0) begin n_err++; $display("FAIL par_off_pe: got %0d want 0", n_pe); end
        n_vec++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL par_off_level: got %b want 0", parity_err); end
`endif
    endtask

    task automatic test_strobe_rules;
        n_vec++; if (n_overlap !== 0) begin n_err++; $display("FAIL strobe_overlap: got %0d want 0", n_overlap); end
        n_vec++; if (n_wide !== 0) begin n_err++; $display("FAIL strobe_width: got %0d want 0", n_wide); end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        i_rst_n   = 1'b0;
        serial_in = 1'b1;
        @(negedge i_clk);
        test_reset();
        test_good_byte();
        test_glitch();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        test_parity();
        test_strobe_rules();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
